// File: rtl/miriscv_fetch_buffer.sv
// Instruction fetch stage: credit-limited sequential fetch over req/gnt/rvalid into a small FIFO.
// Optional misaligned-redirect trap entry is built when MIRISCV_FETCH_ALIGN_CHECK_EN is defined.
module miriscv_fetch_buffer #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_err_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   discard_q, discard_d;
    logic [31:0]        req_pc_q, req_pc_d;
    logic [31:0]        resp_pc_q, resp_pc_d;

    logic [31:0]        instr_mem [DEPTH];
    logic [31:0]        pc_mem    [DEPTH];

    logic [CNT_W:0]     in_use;
    logic               gnt_fire;
    logic               rsp_vld;
    logic               rsp_drop;
    logic               rsp_push;
    logic               push;
    logic               pop;
    logic               halt;
    logic [31:0]        push_instr;
    logic [31:0]        push_pc;
    logic [31:0]        redirect_pc_aligned;

`ifdef MIRISCV_FETCH_ALIGN_CHECK_EN
    logic               halt_q, halt_d;
    logic               pend_q, pend_d;
    logic [31:0]        err_pc_q, err_pc_d;
    logic               err_push;
    logic               push_err;
    logic               err_mem [DEPTH];
`endif

    always_comb begin : fsm_next
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin : handshake
        redirect_pc_aligned = redirect_pc_i & ~32'h3;
        in_use = {1'b0, count_q} + {1'b0, outstanding_q};
        // Stray post-reset responses are not tracked, so never count below zero.
        rsp_vld = instr_rvalid_i && (outstanding_q != '0);
`ifdef MIRISCV_FETCH_ALIGN_CHECK_EN
        halt     = halt_q;
        err_push = pend_q && (outstanding_q == '0) && !redirect_i;
`else
        halt     = 1'b0;
`endif
        instr_req_o  = (state_q == StRun) && (in_use < DEPTH_EXT) && !redirect_i && !halt;
        instr_addr_o = req_pc_q;
        gnt_fire     = instr_req_o && instr_gnt_i;
        rsp_drop     = rsp_vld && (discard_q != '0);
        rsp_push     = rsp_vld && (discard_q == '0) && !redirect_i;
        fetch_valid_o = (count_q != '0);
        pop          = fetch_valid_o && fetch_ready_i && !redirect_i;
`ifdef MIRISCV_FETCH_ALIGN_CHECK_EN
        push = rsp_push || err_push;
`else
        push = rsp_push;
`endif
    end

    always_comb begin : push_data
        push_instr = instr_rdata_i;
        push_pc    = resp_pc_q;
`ifdef MIRISCV_FETCH_ALIGN_CHECK_EN
        push_err   = 1'b0;
        if (err_push) begin
            push_instr = 32'h0000_0013;
            push_pc    = err_pc_q;
            push_err   = 1'b1;
        end
`endif
    end

    always_comb begin : ctrl_next
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(rsp_vld);
        discard_d     = discard_q;
        req_pc_d      = req_pc_q;
        resp_pc_d     = resp_pc_q;
        if (redirect_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            // Everything still in flight after this cycle belongs to the old stream.
            discard_d = outstanding_d;
            req_pc_d  = redirect_pc_aligned;
            resp_pc_d = redirect_pc_aligned;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (rsp_drop) discard_d = discard_q - CNT_W'(1);
            if (gnt_fire) req_pc_d  = req_pc_q + 32'd4;
            if (rsp_push) resp_pc_d = resp_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            req_pc_q      <= RESET_PC;
            resp_pc_q     <= RESET_PC;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            req_pc_q      <= req_pc_d;
            resp_pc_q     <= resp_pc_d;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (push) begin
            instr_mem[wr_ptr_q] <= push_instr;
            pc_mem[wr_ptr_q]    <= push_pc;
        end
    end

    assign fetch_instr_o = instr_mem[rd_ptr_q];
    assign fetch_pc_o    = pc_mem[rd_ptr_q];

`ifdef MIRISCV_FETCH_ALIGN_CHECK_EN
    // A misaligned target parks fetch and queues one error entry once old responses drain.
    always_comb begin : align_next
        halt_d   = halt_q;
        pend_d   = pend_q;
        err_pc_d = err_pc_q;
        if (redirect_i) begin
            halt_d   = (redirect_pc_i[1:0] != 2'b00);
            pend_d   = (redirect_pc_i[1:0] != 2'b00);
            err_pc_d = redirect_pc_i;
        end else if (err_push) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            halt_q   <= 1'b0;
            pend_q   <= 1'b0;
            err_pc_q <= '0;
        end else begin
            halt_q   <= halt_d;
            pend_q   <= pend_d;
            err_pc_q <= err_pc_d;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                err_mem[i] <= 1'b0;
            end
        end else if (push) begin
            err_mem[wr_ptr_q] <= push_err;
        end
    end

    assign fetch_err_o = err_mem[rd_ptr_q];
`else
    assign fetch_err_o = 1'b0;
`endif

    push_into_full_a : assert property (@(posedge clk_i) disable iff (!arstn_i)
        !(push && (count_q == DEPTH_CNT)));

endmodule

// File: tb/tb_miriscv_fetch_buffer.sv
// Directed bench for miriscv_fetch_buffer with an in-order memory that answers one cycle after gnt.
module tb_miriscv_fetch_buffer;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_err_o;

    int          checks = 0;
    int          errors = 0;
    int          fires  = 0;
    int          fires_mark;
    logic        rsp_en = 1'b1;
    logic [31:0] rsp_q [$];

    miriscv_fetch_buffer #(
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i          (clk_i),
        .arstn_i        (arstn_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_ready_i  (fetch_ready_i),
        .fetch_instr_o  (fetch_instr_o),
        .fetch_pc_o     (fetch_pc_o),
        .fetch_err_o    (fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_rsp();
        instr_rvalid_i = rsp_en && (rsp_q.size() > 0);
        instr_rdata_i  = (rsp_q.size() > 0) ? rsp_q[0] : 32'h0;
    endtask

    task automatic set_rsp(input logic en);
        rsp_en = en;
        drive_rsp();
    endtask

    // Advance one cycle; memory data equals the requested address.
    task automatic tick();
        logic        fire;
        logic        took;
        logic [31:0] faddr;
        @(negedge clk_i);
        fire  = instr_req_o && instr_gnt_i;
        faddr = instr_addr_o;
        took  = instr_rvalid_i;
        @(posedge clk_i);
        #1;
        if (took && rsp_q.size() > 0) void'(rsp_q.pop_front());
        if (fire) begin
            rsp_q.push_back(faddr);
            fires++;
        end
        drive_rsp();
    endtask

    task automatic expect_seq(input string tag, input logic [31:0] first, input int n,
                              input int budget);
        logic [31:0] exp_pc = first;
        int          got    = 0;
        fetch_ready_i = 1'b1;
        for (int c = 0; c < budget && got < n; c++) begin
            if (fetch_valid_o) begin
                check({tag, "_pc"}, fetch_pc_o, exp_pc);
                check({tag, "_instr"}, fetch_instr_o, exp_pc);
                check({tag, "_err"}, 32'(fetch_err_o), 32'h0);
                exp_pc += 32'd4;
                got++;
            end
            tick();
        end
        check({tag, "_count"}, 32'(got), 32'(n));
    endtask

    task automatic drain();
        instr_gnt_i   = 1'b0;
        fetch_ready_i = 1'b1;
        set_rsp(1'b1);
        repeat (4) tick();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        tick();
        redirect_i    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arstn_i        = 1'b0;
        instr_gnt_i    = 1'b1;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'h0;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        fetch_ready_i  = 1'b1;
        #2;
        check("rst_req",   32'(instr_req_o), 32'h0);
        check("rst_addr",  instr_addr_o, 32'h0);
        check("rst_valid", 32'(fetch_valid_o), 32'h0);
        check("rst_instr", fetch_instr_o, 32'h0);
        check("rst_pc",    fetch_pc_o, 32'h0);
        check("rst_err",   32'(fetch_err_o), 32'h0);
        #24;
        arstn_i = 1'b1;

        // Cycle 0 is the idle cycle; first gnt in cycle 1, first valid in cycle 3.
        check("idle_req", 32'(instr_req_o), 32'h0);
        tick();
        check("c1_req",  32'(instr_req_o), 32'h1);
        check("c1_addr", instr_addr_o, 32'h0);
        tick();
        check("c2_addr",  instr_addr_o, 32'h4);
        check("c2_valid", 32'(fetch_valid_o), 32'h0);
        tick();
        check("c3_valid", 32'(fetch_valid_o), 32'h1);
        check("c3_pc",    fetch_pc_o, 32'h0);
        check("c3_instr", fetch_instr_o, 32'h0);
        check("c3_req",   32'(instr_req_o), 32'h0);
        tick();
        check("c4_pc",    fetch_pc_o, 32'h4);
        check("c4_instr", fetch_instr_o, 32'h4);
        check("c4_addr",  instr_addr_o, 32'h8);
        tick();
        check("c5_valid", 32'(fetch_valid_o), 32'h0);
        check("c5_addr",  instr_addr_o, 32'hC);
        tick();
        check("c6_pc",    fetch_pc_o, 32'h8);

        // Decode stall: credit is exhausted, FIFO fills, head holds.
        fetch_ready_i = 1'b0;
        fires_mark    = fires;
        repeat (10) tick();
        check("stall_req",   32'(instr_req_o), 32'h0);
        check("stall_valid", 32'(fetch_valid_o), 32'h1);
        check("stall_pc",    fetch_pc_o, 32'h8);
        check("stall_fires", 32'(fires - fires_mark), 32'h0);
        expect_seq("resume", 32'h8, 4, 20);

        // Flush a non-empty FIFO, then hold gnt low.
        fetch_ready_i = 1'b0;
        repeat (3) tick();
        check("pre_flush_valid", 32'(fetch_valid_o), 32'h1);
        fetch_ready_i = 1'b1;
        instr_gnt_i   = 1'b0;
        redirect_to(32'h40);
        check("flush_valid", 32'(fetch_valid_o), 32'h0);
        repeat (3) tick();
        fires_mark = fires;
        for (int i = 0; i < 5; i++) begin
            check("nognt_req",   32'(instr_req_o), 32'h1);
            check("nognt_addr",  instr_addr_o, 32'h40);
            check("nognt_valid", 32'(fetch_valid_o), 32'h0);
            tick();
        end
        check("nognt_fires", 32'(fires - fires_mark), 32'h0);
        instr_gnt_i = 1'b1;
        expect_seq("gnt_back", 32'h40, 3, 20);

        // Two outstanding (0x8, 0xC) discarded by a redirect to 0x100.
        drain();
        set_rsp(1'b0);
        instr_gnt_i = 1'b1;
        redirect_to(32'h8);
        check("os_addr0", instr_addr_o, 32'h8);
        tick();
        check("os_addr1", instr_addr_o, 32'hC);
        tick();
        check("os_req_full", 32'(instr_req_o), 32'h0);
        redirect_to(32'h100);
        check("rd_valid_after", 32'(fetch_valid_o), 32'h0);
        set_rsp(1'b1);
        expect_seq("rd100", 32'h100, 2, 20);

        // Redirect with gnt high and a response arriving: one response left to drop.
        drain();
        set_rsp(1'b0);
        instr_gnt_i = 1'b1;
        redirect_to(32'h200);
        tick();
        tick();
        set_rsp(1'b1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        #1;
        check("co_req_forced", 32'(instr_req_o), 32'h0);
        check("co_rvalid_in",  32'(instr_rvalid_i), 32'h1);
        tick();
        redirect_i = 1'b0;
        check("co_valid_after", 32'(fetch_valid_o), 32'h0);
        expect_seq("rd300", 32'h300, 2, 20);

`ifdef MIRISCV_FETCH_ALIGN_CHECK_EN
        drain();
        instr_gnt_i = 1'b1;
        fires_mark  = fires;
        redirect_to(32'h102);
        begin
            int waited = 0;
            while (!fetch_valid_o && waited < 10) begin
                tick();
                waited++;
            end
            check("al_seen",  32'(fetch_valid_o), 32'h1);
            check("al_pc",    fetch_pc_o, 32'h102);
            check("al_instr", fetch_instr_o, 32'h13);
            check("al_err",   32'(fetch_err_o), 32'h1);
        end
        repeat (5) tick();
        check("al_req",   32'(instr_req_o), 32'h0);
        check("al_fires", 32'(fires - fires_mark), 32'h0);
        check("al_empty", 32'(fetch_valid_o), 32'h0);
        redirect_to(32'h200);
        expect_seq("al_resume", 32'h200, 2, 20);
`else
        drain();
        instr_gnt_i = 1'b1;
        redirect_to(32'h106);
        expect_seq("mask", 32'h104, 2, 20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
